// File: rtl/tea_cipher_core.sv
// tea_cipher_core
//   Iterative TEA block cipher, one full TEA cycle (two Feistel half-rounds)
//   per clock. A block is accepted with a valid/ready handshake, processed
//   for ROUNDS clocks, then held in data_out until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a block is offered on data_in/key/decrypt
//   in_ready   core is idle and accepts a block
//   decrypt    0 = encrypt, 1 = decrypt (latched on accept)
//   key        128-bit key {k0,k1,k2,k3} (latched on accept)
//   data_in    64-bit block {v0,v1} (latched on accept)
//   out_valid  data_out holds a finished result
//   out_ready  consumer takes the result
//   data_out   result {v0,v1}
//   busy       rounds are in progress

module tea_cipher_core #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [63:0]  data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [6:0]  ROUNDS_CNT   = 7'(ROUNDS);
    // Decryption starts from the sum encryption ends with.
    localparam logic [31:0] SUM_DEC_INIT = DELTA * 32'(ROUNDS);

    state_t        state_q, state_d;
    logic [6:0]    cnt_q,   cnt_d;
    logic [31:0]   sum_q,   sum_d;
    logic [31:0]   v0_q,    v0_d;
    logic [31:0]   v1_q,    v1_d;
    logic [127:0]  key_q,   key_d;
    logic          dec_q,   dec_d;

    logic [31:0]   k0, k1, k2, k3;
    logic [31:0]   enc_sum, enc_v0, enc_v1;
    logic [31:0]   dec_sum, dec_v0, dec_v1;

    function automatic logic [31:0] tea_f(
        input logic [31:0] x,
        input logic [31:0] ka,
        input logic [31:0] kb,
        input logic [31:0] s
    );
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid)      state_d = S_RUN;
            S_RUN:   if (cnt_q == 7'd1) state_d = S_DONE;
            S_DONE:  if (out_ready)     state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_RUN);
        out_valid = (state_q == S_DONE);
        data_out  = {v0_q, v1_q};
    end

    // One full TEA cycle in each direction
    always_comb begin
        k0 = key_q[127:96];
        k1 = key_q[95:64];
        k2 = key_q[63:32];
        k3 = key_q[31:0];

        enc_sum = sum_q + DELTA;
        enc_v0  = v0_q + tea_f(v1_q, k0, k1, enc_sum);
        enc_v1  = v1_q + tea_f(enc_v0, k2, k3, enc_sum);

        // Decrypt undoes the half-rounds in reverse order: v1 first.
        dec_v1  = v1_q - tea_f(v0_q, k2, k3, sum_q);
        dec_v0  = v0_q - tea_f(dec_v1, k0, k1, sum_q);
        dec_sum = sum_q - DELTA;
    end

    // Datapath next-state
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        v0_d  = v0_q;
        v1_d  = v1_q;
        key_d = key_q;
        dec_d = dec_q;
        if (state_q == S_IDLE && in_valid) begin
            key_d = key;
            dec_d = decrypt;
            v0_d  = data_in[63:32];
            v1_d  = data_in[31:0];
            sum_d = decrypt ? SUM_DEC_INIT : '0;
            cnt_d = ROUNDS_CNT;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q - 7'd1;
            if (dec_q) begin
                v0_d  = dec_v0;
                v1_d  = dec_v1;
                sum_d = dec_sum;
            end else begin
                v0_d  = enc_v0;
                v1_d  = enc_v1;
                sum_d = enc_sum;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sum_q <= '0;
            v0_q  <= '0;
            v1_q  <= '0;
            key_q <= '0;
            dec_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            key_q <= key_d;
            dec_q <= dec_d;
        end
    end

endmodule

// File: tb/tb_tea_cipher_core.sv
// tb_tea_cipher_core
//   Four instances of tea_cipher_core (ROUNDS = 1, 8, 32, 64) sharing clock
//   and reset, checked against a loop-based TEA reference model.

module tb_tea_cipher_core;

    localparam logic [31:0] DELTA_TB = 32'h9E3779B9;
    localparam int          RND [4]  = '{1, 8, 32, 64};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic         decrypt   [4];
    logic [127:0] key       [4];
    logic [63:0]  data_in   [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [63:0]  data_out  [4];
    logic         busy      [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tea_cipher_core #(
            .ROUNDS(RND[g]),
            .DELTA (DELTA_TB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .decrypt  (decrypt[g]),
            .key      (key[g]),
            .data_in  (data_in[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .data_out (data_out[g]),
            .busy     (busy[g])
        );
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference TEA: straight loops over the round equations.
    function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] d,
                                            input bit dec, input int rounds);
        logic [31:0] v0, v1, s, k0, k1, k2, k3;
        v0 = d[63:32];
        v1 = d[31:0];
        k0 = k[127:96];
        k1 = k[95:64];
        k2 = k[63:32];
        k3 = k[31:0];
        if (!dec) begin
            s = 32'd0;
            for (int r = 0; r < rounds; r++) begin
                s  = s + DELTA_TB;
                v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
                v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
            end
        end else begin
            s = DELTA_TB * 32'(rounds);
            for (int r = 0; r < rounds; r++) begin
                v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
                v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
                s  = s - DELTA_TB;
            end
        end
        return {v0, v1};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] rand_blk();
        return {$urandom(), $urandom()};
    endfunction

    // Offer one block, wait for the result, hand it off. Inputs are scrambled
    // right after acceptance so the latch on accept is exercised.
    task automatic run_block(input int i, input bit dec, input logic [127:0] k,
                             input logic [63:0] d, output logic [63:0] res);
        int lat;
        @(negedge clk);
        in_valid[i]  = 1'b1;
        decrypt[i]   = dec;
        key[i]       = k;
        data_in[i]   = d;
        out_ready[i] = 1'b0;
        check_val("in_ready_before_accept", 64'(in_ready[i]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        decrypt[i]  = ~dec;
        key[i]      = ~k;
        data_in[i]  = ~d;
        check_val("busy_in_run", 64'(busy[i]), 64'd1);
        check_val("in_ready_in_run", 64'(in_ready[i]), 64'd0);
        lat = 0;
        while (!out_valid[i] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val("latency", 64'(lat), 64'(RND[i]));
        res = data_out[i];
        out_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[i] = 1'b0;
        check_val("in_ready_after_handoff", 64'(in_ready[i]), 64'd1);
        check_val("out_valid_after_handoff", 64'(out_valid[i]), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [127:0] k;
        logic [63:0]  d, r1, r2, held, exp_q[$];
        int           cyc, last_acc, n_acc, n_out;

        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            decrypt[i]   = 1'b0;
            key[i]       = '0;
            data_in[i]   = '0;
            out_ready[i] = 1'b0;
        end

        // Reset values
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            check_val("rst_data_out", data_out[i], 64'd0);
            check_val("rst_out_valid", 64'(out_valid[i]), 64'd0);
            check_val("rst_busy", 64'(busy[i]), 64'd0);
        end
        #19 rst = 1'b0;
        #1;
        check_val("in_ready_after_rst", 64'(in_ready[2]), 64'd1);

        // Known-answer vectors
        run_block(2, 1'b0, '0, '0, r1);
        check_val("kat_encrypt", r1, 64'h41EA3A0A_94BAA940);
        run_block(2, 1'b1, '0, 64'h41EA3A0A_94BAA940, r1);
        check_val("kat_decrypt", r1, 64'h0);

        // Random round trips at every ROUNDS value
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 3; n++) begin
                k = rand_key();
                d = rand_blk();
                run_block(i, 1'b0, k, d, r1);
                check_val("rand_encrypt", r1, tea_ref(k, d, 1'b0, RND[i]));
                run_block(i, 1'b1, k, r1, r2);
                check_val("rand_roundtrip", r2, d);
            end
        end

        // Output stall with in_valid toggling
        k = rand_key();
        d = rand_blk();
        @(negedge clk);
        in_valid[2] = 1'b1;
        decrypt[2]  = 1'b0;
        key[2]      = k;
        data_in[2]  = d;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!out_valid[2] && cyc < 200) begin
            in_valid[2] = ~in_valid[2];
            data_in[2]  = rand_blk();
            @(negedge clk);
            cyc++;
        end
        check_val("stall_latency", 64'(cyc), 64'd32);
        held = data_out[2];
        check_val("stall_result", held, tea_ref(k, d, 1'b0, 32));
        for (int c = 0; c < 10; c++) begin
            in_valid[2] = ~in_valid[2];
            data_in[2]  = rand_blk();
            key[2]      = rand_key();
            @(negedge clk);
            check_val("stall_data_out", data_out[2], held);
            check_val("stall_out_valid", 64'(out_valid[2]), 64'd1);
            check_val("stall_in_ready", 64'(in_ready[2]), 64'd0);
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[2] = 1'b0;
        check_val("stall_release_in_ready", 64'(in_ready[2]), 64'd1);

        // Asynchronous reset in the middle of round processing
        k = rand_key();
        d = rand_blk();
        @(negedge clk);
        in_valid[2] = 1'b1;
        key[2]      = k;
        data_in[2]  = d;
        decrypt[2]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (5) @(negedge clk);
        check_val("busy_before_abort", 64'(busy[2]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("abort_data_out", data_out[2], 64'd0);
        check_val("abort_out_valid", 64'(out_valid[2]), 64'd0);
        check_val("abort_busy", 64'(busy[2]), 64'd0);
        #1 rst = 1'b0;
        #0;
        check_val("abort_in_ready", 64'(in_ready[2]), 64'd1);
        repeat (12) @(negedge clk);
        check_val("abort_no_late_result", 64'(out_valid[2]), 64'd0);
        k = rand_key();
        d = rand_blk();
        run_block(2, 1'b0, k, d, r1);
        check_val("post_abort_result", r1, tea_ref(k, d, 1'b0, 32));

        // Back-to-back with in_valid and out_ready held high (ROUNDS = 8)
        k = rand_key();
        @(negedge clk);
        key[1]       = k;
        decrypt[1]   = 1'b0;
        data_in[1]   = rand_blk();
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        cyc = 0;
        last_acc = -1;
        n_acc = 0;
        n_out = 0;
        while (n_out < 4 && cyc < 400) begin
            if (out_valid[1]) begin
                check_val("b2b_result", data_out[1], exp_q.pop_front());
                n_out++;
            end
            if (in_ready[1] && in_valid[1]) begin
                exp_q.push_back(tea_ref(k, data_in[1], 1'b0, 8));
                if (last_acc >= 0) check_val("b2b_spacing", 64'(cyc - last_acc), 64'd10);
                last_acc = cyc;
                n_acc++;
            end else begin
                data_in[1] = rand_blk();
                if (n_acc == 4) in_valid[1] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check_val("b2b_outputs", 64'(n_out), 64'd4);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
